// File: rtl/comp_serial_8bit.sv
// Bit-serial unsigned magnitude comparator: captures A/B on start and walks the
// operands MSB-first, one bit per clock, returning registered G/E/L with a done pulse.
module comp_serial_8bit #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             E,
  output logic             L
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx;
  logic             diff_found, diff_gt;
  logic             accept, decide, cur_diff, any_diff, gt_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The highest differing bit wins; gt_now folds in the bit under test when
  // nothing has been recorded yet so the decision edge needs no extra cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    decide     = 1'b0;
    cur_diff   = a_reg[idx] ^ b_reg[idx];
    any_diff   = diff_found | cur_diff;
    gt_now     = diff_found ? diff_gt : a_reg[idx];
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if ((cur_diff && EARLY_EXIT) || (idx == '0)) begin
          decide     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= '0;
      diff_found <= 1'b0;
      diff_gt    <= 1'b0;
      done       <= 1'b0;
      G          <= 1'b0;
      E          <= 1'b0;
      L          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg      <= A;
        b_reg      <= B;
        idx        <= IW'(WIDTH - 1);
        diff_found <= 1'b0;
        diff_gt    <= 1'b0;
      end else if (state == SHIFT) begin
        if (decide) begin
          done <= 1'b1;
          G    <= any_diff & gt_now;
          L    <= any_diff & ~gt_now;
          E    <= ~any_diff;
        end else begin
          idx <= idx - 1'b1;
          if (cur_diff && !diff_found) begin
            diff_found <= 1'b1;
            diff_gt    <= a_reg[idx];
          end
        end
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule
